pc_fetch_unit: RTL and testbench

//   Holds the program counter and fetches 32-bit instructions from instruction memory over a req/ready handshake.

---
 rtl/legv8_pkg.sv | 21 ++
 rtl/branch_target_adder.sv | 14 +
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared constants and types for the LEGv8 fetch front end.
package legv8_pkg;

  localparam int LEGV8_ADDR_W  = 64;
  localparam int LEGV8_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  // Opcode fields of the two branch classes the fetch unit redirects on.
  localparam logic [5:0] OPC_B   = 6'b000101;
  localparam logic [7:0] OPC_CBZ = 8'b10110100;

  typedef enum logic {
    S_FETCH,
    S_ISSUE
  } fetch_state_t;

  function automatic logic branch_taken(input logic uncond, input logic cond, input logic zero);
    return uncond | (cond & zero);
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: pc plus a word offset scaled to bytes, modulo 2^ADDR_W.
import legv8_pkg::*;

module branch_target_adder #(
  parameter int ADDR_W = LEGV8_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] target
);

  assign target = pc + (imm << 2);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch over a req/ready handshake.
// Optional FETCH_PERF_CNT_EN adds fetched/taken performance counters.
import legv8_pkg::*;

module pc_fetch_unit #(
  parameter int                ADDR_W   = LEGV8_ADDR_W,
  parameter int                INSTR_W  = LEGV8_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               stall,
  input  logic [ADDR_W-1:0]  sign_ext_imm,
  input  logic               uncond_branch,
  input  logic               cond_branch,
  input  logic               alu_zero
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_taken
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] next_pc;
  logic              taken;
  logic              consume;

  branch_target_adder #(
    .ADDR_W (ADDR_W)
  ) u_branch_target_adder (
    .pc     (pc),
    .imm    (sign_ext_imm),
    .target (branch_target)
  );

  assign taken     = branch_taken(uncond_branch, cond_branch, alu_zero);
  assign next_pc   = taken ? branch_target : pc + ADDR_W'(PC_STEP);
  assign consume   = (state == S_ISSUE) && !stall;
  assign imem_addr = pc;
  assign pc_out    = pc;

  // A capture needs imem_req already high, so a ready arriving right after
  // reset is ignored; the consume edge re-raises imem_req for 2-cycle throughput.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_taken   <= '0;
    end else if (consume) begin
      perf_fetched <= perf_fetched + 32'd1;
      if (taken) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit (RESET_PC = 0x100).
module tb_pc_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic        stall;
  logic [63:0] sign_ext_imm;
  logic        uncond_branch;
  logic        cond_branch;
  logic        alu_zero;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_taken;
  int          exp_fetched = 0;
  int          exp_taken = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;

  pc_fetch_unit #(
    .ADDR_W   (64),
    .INSTR_W  (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .stall         (stall),
    .sign_ext_imm  (sign_ext_imm),
    .uncond_branch (uncond_branch),
    .cond_branch   (cond_branch),
    .alu_zero      (alu_zero)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_taken    (perf_taken)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from its address so each fetch is distinguishable.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic await_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic consume(input logic u, input logic c, input logic z, input logic [63:0] imm);
    logic tk;
    tk = u | (c & z);
    uncond_branch = u;
    cond_branch   = c;
    alu_zero      = z;
    sign_ext_imm  = imm;
    stall         = 1'b0;
    exp_pc = tk ? exp_pc + (imm << 2) : exp_pc + 64'd4;
`ifdef FETCH_PERF_CNT_EN
    exp_fetched++;
    if (tk) exp_taken++;
`endif
    step();
    uncond_branch = 1'b0;
    cond_branch   = 1'b0;
    alu_zero      = 1'b0;
    sign_ext_imm  = '0;
  endtask

  task automatic goto_pc(input logic [63:0] target);
    bit ok;
    await_issue(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL goto_timeout actual valid=%0b required 1", instr_valid);
    end
    consume(1'b1, 1'b0, 1'b0, (target - exp_pc) >> 2);
  endtask

  task automatic test_reset();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== RST_PC) begin
      errors++;
      $display("[TB] FAIL reset_state actual req=%b valid=%b instr=%h addr=%h required 0 0 0 %h",
               imem_req, instr_valid, instr, imem_addr, RST_PC);
    end
    reset = 1'b0;
    exp_pc = RST_PC;
    step();
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
      errors++;
      $display("[TB] FAIL reset_first_req actual req=%b valid=%b addr=%h required 1 0 %h",
               imem_req, instr_valid, imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = RST_PC + 64'(4 * i);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_req%0d actual req=%b addr=%h valid=%b required 1 %h 0", i, imem_req, imem_addr, instr_valid, a);
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== mem_word(a) || pc_out !== a || imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_issue%0d actual valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                 i, instr_valid, instr, pc_out, imem_req, mem_word(a), a);
      end
      consume(1'b0, 1'b0, 1'b0, 64'h0);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [63:0] a;
    await_issue(ok);
    a = exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (!ok || instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== mem_word(a) || pc_out !== a) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d actual valid=%b req=%b instr=%h pc=%h required 1 0 %h %h",
                 i, instr_valid, imem_req, instr, pc_out, mem_word(a), a);
      end
    end
    consume(1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (imem_addr !== a + 64'd4 || imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release actual addr=%h req=%b required %h 1", imem_addr, imem_req, a + 64'd4);
    end
  endtask

  task automatic test_uncond_branch();
    bit ok;
    goto_pc(64'h200);
    await_issue(ok);
    consume(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    checks++;
    if (imem_addr !== 64'h1F8) begin
      errors++;
      $display("[TB] FAIL uncond_back actual %h required %h", imem_addr, 64'h1F8);
    end
    goto_pc(64'h200);
    await_issue(ok);
    consume(1'b1, 1'b0, 1'b0, 64'h3);
    checks++;
    if (imem_addr !== 64'h20C) begin
      errors++;
      $display("[TB] FAIL uncond_fwd actual %h required %h", imem_addr, 64'h20C);
    end
    await_issue(ok);
    consume(1'b1, 1'b1, 1'b0, 64'h2);
    checks++;
    if (imem_addr !== 64'h214) begin
      errors++;
      $display("[TB] FAIL both_bits actual %h required %h", imem_addr, 64'h214);
    end
    await_issue(ok);
    consume(1'b1, 1'b0, 1'b0, 64'h0);
    await_issue(ok);
    checks++;
    if (!ok || pc_out !== 64'h214 || instr !== mem_word(64'h214)) begin
      errors++;
      $display("[TB] FAIL branch_self actual pc=%h instr=%h required %h %h", pc_out, instr, 64'h214, mem_word(64'h214));
    end
  endtask

  task automatic test_cond_branch();
    bit ok;
    goto_pc(64'h40);
    await_issue(ok);
    consume(1'b0, 1'b1, 1'b0, 64'h10);
    checks++;
    if (imem_addr !== 64'h44) begin
      errors++;
      $display("[TB] FAIL cbz_not_taken actual %h required %h", imem_addr, 64'h44);
    end
    goto_pc(64'h40);
    await_issue(ok);
    consume(1'b0, 1'b1, 1'b1, 64'h10);
    checks++;
    if (imem_addr !== 64'h80) begin
      errors++;
      $display("[TB] FAIL cbz_taken actual %h required %h", imem_addr, 64'h80);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
    await_issue(ok);
    checks++;
    if (!ok || pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("[TB] FAIL wrap_pc actual %h required %h", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    consume(1'b0, 1'b0, 1'b0, 64'h0);
    checks++;
    if (imem_addr !== 64'h0) begin
      errors++;
      $display("[TB] FAIL wrap_next actual %h required 0", imem_addr);
    end
  endtask

  task automatic test_ready_wait();
    logic [63:0] a;
    a = imem_addr;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_wait%0d actual req=%b addr=%h valid=%b required 1 %h 0", i, imem_req, imem_addr, instr_valid, a);
      end
    end
  endtask

  task automatic test_reset_mid_request();
    bit ok;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abandon actual req=%b valid=%b required 0 0", imem_req, instr_valid);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_pc = RST_PC;
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++;
      $display("[TB] FAIL late_ready actual valid=%b req=%b addr=%h required 0 1 %h", instr_valid, imem_req, imem_addr, RST_PC);
    end
    await_issue(ok);
    checks++;
    if (!ok || instr !== mem_word(RST_PC) || pc_out !== RST_PC) begin
      errors++;
      $display("[TB] FAIL refetch actual instr=%h pc=%h required %h %h", instr, pc_out, mem_word(RST_PC), RST_PC);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_taken !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset actual %0d %0d required 0 0", perf_fetched, perf_taken);
    end
`endif
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    checks++;
    if (perf_fetched !== 32'(exp_fetched) || perf_taken !== 32'(exp_taken)) begin
      errors++;
      $display("[TB] FAIL perf_counts actual %0d %0d required %0d %0d", perf_fetched, perf_taken, exp_fetched, exp_taken);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    imem_ready    = 1'b1;
    stall         = 1'b0;
    sign_ext_imm  = '0;
    uncond_branch = 1'b0;
    cond_branch   = 1'b0;
    alu_zero      = 1'b0;
    exp_pc        = RST_PC;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_uncond_branch();
    test_cond_branch();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_ready_wait();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
